ibuf_debounce_counter: RTL and testbench

- Receive-side counterpart to the tristate output buffer tests: a single-ended input pad passes through an inferred input buffer, a synchronizer, a debouncer and an edge detector.
- Qualified rising edges are counted onto board LEDs.
- Used as a sing_io feature top to prove input-buffer placement and routing on hardware and in post-route simulation.

---
 rtl/ibuf_debounce_counter.sv | 130 +++++++++++++
 tb/tb_ibuf_debounce_counter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ibuf_debounce_counter.sv
// ibuf_debounce_counter
//   The pad jc1 goes through an inferred input buffer, a SYNC_STAGES-deep
//   synchronizer, a DEBOUNCE_CYCLES debouncer and an edge detector.
//   Accepted rising edges are counted onto led.
//
//   Optional feature macro: IBUF_DEBOUNCE_COUNT_FALL_EN
//     defined   : fall pulses are generated and led counts rises and falls
//     undefined : fall is tied to 0 and only rises are counted
//
//   Every output comes from a flop, so there is no combinational path from
//   jc1 to any output. Reset is synchronous and active-high, and it overrides
//   every other action.
module ibuf_debounce_counter #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jc1,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] led
);

  // The debounce counter only has to reach DEBOUNCE_CYCLES-1.
  // The extra bit keeps the width at least 1 when DEBOUNCE_CYCLES is 1.
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);

  // Stop elaboration when a parameter value would break the pipeline.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("ibuf_debounce_counter: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("ibuf_debounce_counter: DEBOUNCE_CYCLES must be >= 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("ibuf_debounce_counter: CNT_W must be >= 1");
  end

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_out;
  logic [DW-1:0]          dcnt;
  logic                   accept;

  assign sync_out = sync[SYNC_STAGES-1];

  // The new value has held for long enough and is committed on this edge.
  assign accept = (sync_out != level) && (dcnt == DLAST);

  // Synchronizer chain: sync[0] samples the pad and each stage copies the one before.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], jc1};
    end
  end

  // Debounce counter: count while sync_out differs from level, and clear
  // when they agree or when the new value is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt <= '0;
    end else if (sync_out == level) begin
      dcnt <= '0;
    end else if (accept) begin
      dcnt <= '0;
    end else begin
      dcnt <= dcnt + DW'(1);
    end
  end

  // Debounced level: it takes the synchronized value only when that value is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= 1'b0;
    end else if (accept) begin
      level <= sync_out;
    end
  end

  // Rising-edge pulse: one cycle, on the same edge that level goes from 0 to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise <= 1'b0;
    end else begin
      rise <= accept && sync_out;
    end
  end

`ifdef IBUF_DEBOUNCE_COUNT_FALL_EN
  logic fall_q;

  // Falling-edge pulse: one cycle, on the same edge that level goes from 1 to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      fall_q <= 1'b0;
    end else begin
      fall_q <= accept && !sync_out;
    end
  end

  assign fall = fall_q;

  // Event counter: counts accepted transitions in both directions and wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      led <= '0;
    end else if (accept) begin
      led <= led + CNT_W'(1);
    end
  end
`else
  // Falling transitions still update level, but no fall pulse exists.
  assign fall = 1'b0;

  // Event counter: counts accepted rising transitions and wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      led <= '0;
    end else if (accept && sync_out) begin
      led <= led + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ibuf_debounce_counter.sv
// Directed bench for ibuf_debounce_counter (default parameters).
// It builds with or without IBUF_DEBOUNCE_COUNT_FALL_EN.
module tb_ibuf_debounce_counter;

`ifdef IBUF_DEBOUNCE_COUNT_FALL_EN
  localparam logic FALL_ON = 1'b1;
`else
  localparam logic FALL_ON = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       jc1;
  logic       level;
  logic       rise;
  logic       fall;
  logic [3:0] led;

  int checks = 0;
  int errors = 0;
  logic [3:0] led_exp;
  int pulse_n;

  ibuf_debounce_counter #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .jc1(jc1),
    .level(level),
    .rise(rise),
    .fall(fall),
    .led(led)
  );

  // clock: 10 ns period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic l, input logic r, input logic f,
                         input logic [3:0] c);
    chk({tag, ".level"}, {31'd0, level}, {31'd0, l});
    chk({tag, ".rise"},  {31'd0, rise},  {31'd0, r});
    chk({tag, ".fall"},  {31'd0, fall},  {31'd0, f});
    chk({tag, ".led"},   {28'd0, led},   {28'd0, c});
  endtask

  initial begin
    rst = 1'b1;
    jc1 = 1'b0;
    led_exp = 4'd0;

    // 1: reset for two cycles, then pad held low for 20 cycles
    tick();
    tick();
    chk_all("t1_reset", 1'b0, 1'b0, 1'b0, 4'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_all("t1_idle", 1'b0, 1'b0, 1'b0, 4'd0);
    end

    // 2: pad 0->1; sync[0] captures it at edge k, level and rise appear at edge k+5
    jc1 = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      tick();
      chk_all("t2_wait", 1'b0, 1'b0, 1'b0, 4'd0);
    end
    tick();
    chk("t2_k5.level", {31'd0, level}, 32'd1);
    chk("t2_k5.rise",  {31'd0, rise},  32'd1);
    led_exp = 4'd1;
    tick();
    chk_all("t2_k6", 1'b1, 1'b0, 1'b0, led_exp);

    // 6: pad 1->0 held for 8 cycles, starting from level=1
    jc1 = 1'b0;
    for (int i = 0; i <= 4; i++) begin
      tick();
      chk_all("t6_wait", 1'b1, 1'b0, 1'b0, led_exp);
    end
    tick();
    chk("t6_k5.level", {31'd0, level}, 32'd0);
    chk("t6_k5.fall",  {31'd0, fall},  {31'd0, FALL_ON});
    if (FALL_ON) led_exp = led_exp + 4'd1;
    tick();
    chk_all("t6_k6", 1'b0, 1'b0, 1'b0, led_exp);
    tick();

    // 3: a 3-cycle high glitch must be rejected
    jc1 = 1'b1;
    tick();
    tick();
    tick();
    jc1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_all("t3_glitch", 1'b0, 1'b0, 1'b0, led_exp);
    end

    // 4: after a fresh reset, 17 accepted rises with 8-cycle high and low phases
    rst = 1'b1;
    tick();
    rst = 1'b0;
    led_exp = 4'd0;
    chk("t4_reset.led", {28'd0, led}, 32'd0);
    for (int n = 1; n <= 17; n++) begin
      jc1 = 1'b1;
      pulse_n = 0;
      for (int i = 0; i < 8; i++) begin
        tick();
        pulse_n += int'(rise);
      end
      led_exp = led_exp + 4'd1;
      chk("t4_rise_pulses", pulse_n, 32'd1);
      chk("t4_led_after_rise", {28'd0, led}, {28'd0, led_exp});
      chk("t4_level_high", {31'd0, level}, 32'd1);
      jc1 = 1'b0;
      pulse_n = 0;
      for (int i = 0; i < 8; i++) begin
        tick();
        pulse_n += int'(fall);
      end
      if (FALL_ON) led_exp = led_exp + 4'd1;
      chk("t4_fall_pulses", pulse_n, {31'd0, FALL_ON});
      chk("t4_led_after_fall", {28'd0, led}, {28'd0, led_exp});
      chk("t4_level_low", {31'd0, level}, 32'd0);
    end

    // 5: reset pulsed at edge k+3 while a 0->1 is still being debounced
    jc1 = 1'b1;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk_all("t5_reset", 1'b0, 1'b0, 1'b0, 4'd0);
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk_all("t5_wait", 1'b0, 1'b0, 1'b0, 4'd0);
    end
    tick();
    chk("t5_r6.rise",  {31'd0, rise},  32'd1);
    chk("t5_r6.level", {31'd0, level}, 32'd1);
    tick();
    chk_all("t5_r7", 1'b1, 1'b0, 1'b0, 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
